coin_acceptor: RTL

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/soda_pkg.sv | 38 +++
 rtl/coin_acceptor_if.sv | 17 +
 rtl/btn_sync.sv | 26 ++
 rtl/coin_acceptor.sv | 110 +++++++++++
 4 files changed

// File: rtl/soda_pkg.sv
// Coin constants, acceptor state encoding and button-to-value decode shared by the soda datapath.
// COIN_ACCEPTOR_DOLLAR_EN adds a fourth (dollar) coin button.
package soda_pkg;

`ifdef COIN_ACCEPTOR_DOLLAR_EN
   localparam int NUM_BTN = 4;
`else
   localparam int NUM_BTN = 3;
`endif

   localparam int COIN_VAL_W = 7;

   localparam logic [COIN_VAL_W-1:0] COIN_NICKEL  = 7'd5;
   localparam logic [COIN_VAL_W-1:0] COIN_DIME    = 7'd10;
   localparam logic [COIN_VAL_W-1:0] COIN_QUARTER = 7'd25;
   localparam logic [COIN_VAL_W-1:0] COIN_DOLLAR  = 7'd100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_EMIT,
      ST_RELEASE
   } acc_state_e;

   // Code is one-hot by construction, so at most one branch fires.
   function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [NUM_BTN-1:0] code);
      logic [COIN_VAL_W-1:0] val;
      val = '0;
      if (code[0]) val = COIN_NICKEL;
      if (code[1]) val = COIN_DIME;
      if (code[2]) val = COIN_QUARTER;
`ifdef COIN_ACCEPTOR_DOLLAR_EN
      if (code[3]) val = COIN_DOLLAR;
`endif
      return val;
   endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin button inputs and coin-in handshake toward the soda controller.
// Button width follows COIN_ACCEPTOR_DOLLAR_EN through soda_pkg::NUM_BTN.
interface coin_acceptor_if #(
   parameter int WIDTH = 8
);
   import soda_pkg::*;

   logic [NUM_BTN-1:0] coin_btn;
   logic               c;
   logic [WIDTH-1:0]   a;
   logic               rej;
   logic               busy;

   modport master (output coin_btn, input c, a, rej, busy);
   modport slave  (input coin_btn, output c, a, rej, busy);

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer bringing the raw asynchronous buttons into the clk domain.
module btn_sync #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Debounced coin acceptor: one c pulse per clean single-button press, rej on multi-press.
// COIN_ACCEPTOR_DOLLAR_EN widens the button vector to include a dollar coin.
module coin_acceptor
   import soda_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input logic             clk,
   input logic             rst,
   coin_acceptor_if.slave  bus
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [NUM_BTN-1:0] btn_s;
   logic               any_btn;

   acc_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_BTN-1:0] code_q, code_d;
   logic               c_q, c_d;
   logic               rej_q, rej_d;
   logic [WIDTH-1:0]   a_q, a_d;

   btn_sync #(.W(NUM_BTN)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.coin_btn),
      .q_o (btn_s)
   );

   assign any_btn = |btn_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         code_q  <= '0;
         c_q     <= 1'b0;
         rej_q   <= 1'b0;
         a_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         c_q     <= c_d;
         rej_q   <= rej_d;
         a_q     <= a_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      c_d     = 1'b0;
      rej_d   = 1'b0;
      a_d     = a_q;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if ($onehot(btn_s)) begin
               code_d  = btn_s;
               state_d = ST_DEBOUNCE;
            end else if (any_btn) begin
               rej_d   = 1'b1;
               state_d = ST_RELEASE;
            end
         end
         ST_DEBOUNCE: begin
            // Any change, including release, abandons the press without touching a.
            if (btn_s != code_q) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_EMIT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_EMIT: begin
            c_d     = 1'b1;
            a_d     = WIDTH'(coin_value(code_q));
            cnt_d   = '0;
            state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (any_btn) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.c    = c_q;
   assign bus.a    = a_q;
   assign bus.rej  = rej_q;
   assign bus.busy = (state_q != ST_IDLE);

endmodule
